phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter TMR_W, default 16, width of the per-phase timeout counter and of timeout_limit.
REQ-002 SHALL have parameter CNT_W, default 16, width of round_count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one round; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous abort of the current round.
REQ-007 SHALL have port phase_en  input  8  enabled phases; bit i = phase i; latched on accepted start.
REQ-008 SHALL have port timeout_limit  input  TMR_W  maximum WAIT cycles per phase; 0 disables the timeout.
REQ-009 SHALL have port phase_done  input  1  completion pulse from the active phase engine.
REQ-010 SHALL have port select  output  3  phase index to the 8:1 address mux (0 learnCost … 7 selectMyAction).
REQ-011 SHALL have port phase_start  output  1  one-cycle launch pulse for the phase on select.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port round_done  output  1  one-cycle pulse when a round completes normally.
REQ-014 SHALL have port timeout_err  output  1  sticky timeout flag.
REQ-015 SHALL have port err_phase  output  3  index of the phase that timed out.
REQ-016 SHALL have port round_count  output  CNT_W  count of completed rounds.

Function
REQ-017 SHALL implement the FSM states IDLE, LAUNCH, WAIT and DONE; all outputs SHALL be registered.
REQ-018 IDLE, start=1, phase_en!=0: SHALL latch phase_en, load select with the lowest set bit, and enter LAUNCH.
- Timing: start sampled at edge N gives select valid and phase_start=1 in cycle N+1.
REQ-019 IDLE, start=1, phase_en==0: SHALL go straight to DONE; no phase_start is issued.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 LAUNCH: SHALL assert phase_start for exactly one cycle, clear the timer, and enter WAIT.
- phase_done in the LAUNCH cycle SHALL be ignored.
REQ-022 WAIT: timer SHALL increment each cycle, saturating at its maximum value.
- select SHALL remain stable throughout LAUNCH and WAIT.
REQ-023 WAIT, phase_done=1, a higher-index latched bit remains: SHALL load select with the next set bit and enter LAUNCH.
- Timing: phase_done at cycle M gives the next phase_start in cycle M+1.
- Disabled phases SHALL be skipped with no idle cycles.
REQ-024 WAIT, phase_done=1, no higher latched bit: SHALL enter DONE.
REQ-025 WAIT, timeout_limit!=0, timer==timeout_limit, phase_done=0: SHALL set timeout_err=1, set err_phase=select, and enter IDLE.
- round_done and round_count SHALL be unaffected.
REQ-026 phase_done and the timeout condition in the same cycle: phase_done SHALL take priority.
REQ-027 DONE: SHALL assert round_done for one cycle, increment round_count modulo 2^CNT_W, and enter IDLE.
REQ-028 abort=1 in any state SHALL force IDLE on the next edge.
- Abort SHALL produce no round_done and no phase_start, and SHALL leave round_count unchanged.
- abort SHALL take priority over start, phase_done and timeout.
REQ-029 timeout_err SHALL clear only on an accepted start or on reset.
REQ-030 select SHALL hold its last value while in IDLE.

Reset
REQ-031 While nrst=0 (asynchronous), SHALL force: state IDLE, select=0, phase_start=0, busy=0, round_done=0, timeout_err=0, err_phase=0, round_count=0, timer=0, latched mask=0.
REQ-032 Reset asserted mid-round SHALL abandon the round with no pulse on any output after release.
REQ-033 The first start SHALL be accepted on the first rising edge after nrst deasserts.

Verification
REQ-034 phase_en=8'hFF, phase_done 3 cycles after each phase_start -> select steps 0..7, 8 phase_start pulses, one round_done, round_count=1.
REQ-035 phase_en=8'b1010_0100 -> select sequence 2,5,7 only; phase_start-to-next phase_start spacing = done latency+1.
REQ-036 timeout_limit=4, no phase_done on phase 3 -> timeout_err=1 and err_phase=3 on cycle 4 of WAIT, busy=0 next, round_count unchanged; next start clears timeout_err.
REQ-037 phase_en=0 with start -> round_done two cycles after start, zero phase_start pulses; start during busy -> no effect.
REQ-038 abort during WAIT of phase 5 -> IDLE next cycle, no round_done; nrst low mid-round -> all outputs at reset values immediately.
REQ-039 round_count preset by 2^CNT_W-1 completed rounds (CNT_W=4) -> the next round wraps round_count to 0.

Source files
------------

// File: rtl/phase_sequencer.sv
// Round sequencer: walks the enabled phases in ascending index order, launching each
// phase engine in turn and waiting for its completion pulse, with an optional per-phase timeout.
module phase_sequencer #(
  parameter int TMR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       phase_en,
  input  logic [TMR_W-1:0] timeout_limit,
  input  logic             phase_done,
  output logic [2:0]       select,
  output logic             phase_start,
  output logic             busy,
  output logic             round_done,
  output logic             timeout_err,
  output logic [2:0]       err_phase,
  output logic [CNT_W-1:0] round_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [7:0]       mask_reg;

  logic [7:0]       above_sel;
  logic [7:0]       pending;
  logic [2:0]       next_idx;
  logic [2:0]       first_idx;
  logic             timer_hit;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Phases still to run in this round: latched bits strictly above the current one.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_above
      assign above_sel[gi] = (3'(gi) > select);
    end
  endgenerate

  assign pending   = mask_reg & above_sel;
  assign next_idx  = lowest_idx(pending);
  assign first_idx = lowest_idx(phase_en);
  assign timer_hit = (timeout_limit != '0) && (timer_reg == timeout_limit);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      mask_reg    <= '0;
      select      <= '0;
      phase_start <= 1'b0;
      busy        <= 1'b0;
      round_done  <= 1'b0;
      timeout_err <= 1'b0;
      err_phase   <= '0;
      round_count <= '0;
    end else begin
      phase_start <= 1'b0;
      round_done  <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              mask_reg    <= phase_en;
              timeout_err <= 1'b0;
              busy        <= 1'b1;
              if (phase_en != 8'd0) begin
                select      <= first_idx;
                phase_start <= 1'b1;
                state_reg   <= LAUNCH;
              end else begin
                state_reg <= DONE;
              end
            end
          end
          LAUNCH: begin
            timer_reg <= '0;
            state_reg <= WAIT;
          end
          WAIT: begin
            // Completion wins over a timeout that lands in the same cycle.
            if (phase_done) begin
              if (pending != 8'd0) begin
                select      <= next_idx;
                phase_start <= 1'b1;
                state_reg   <= LAUNCH;
              end else begin
                state_reg <= DONE;
              end
            end else if (timer_hit) begin
              timeout_err <= 1'b1;
              err_phase   <= select;
              busy        <= 1'b0;
              state_reg   <= IDLE;
            end else if (timer_reg != '1) begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          DONE: begin
            round_done  <= 1'b1;
            round_count <= round_count + 1'b1;
            busy        <= 1'b0;
            state_reg   <= IDLE;
          end
          default: begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: expected selects and round counts are queued at
// stimulus time and checked when phase_start / round_done pulses appear.
module tb_phase_sequencer;
  localparam int TMR_W = 16;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       phase_en = 8'd0;
  logic [TMR_W-1:0] timeout_limit = '0;
  logic             phase_done = 1'b0;
  logic [2:0]       select;
  logic             phase_start;
  logic             busy;
  logic             round_done;
  logic             timeout_err;
  logic [2:0]       err_phase;
  logic [CNT_W-1:0] round_count;

  phase_sequencer #(.TMR_W(TMR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .phase_en(phase_en),
    .timeout_limit(timeout_limit), .phase_done(phase_done), .select(select),
    .phase_start(phase_start), .busy(busy), .round_done(round_done),
    .timeout_err(timeout_err), .err_phase(err_phase), .round_count(round_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int exp_sel_q[$];
  int exp_cnt_q[$];
  int exp_count = 0;
  int done_lat = 3;
  int hang_sel = -1;
  int eng_cnt = 0;
  int ps_total = 0;
  int rd_total = 0;
  int last_ps_cyc = 0;
  int prev_ps_cyc = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Phase engine model: completion pulse done_lat cycles after each launch, except a hung phase.
  always @(negedge clk) begin
    phase_done = 1'b0;
    if (!nrst) eng_cnt = 0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) phase_done = 1'b1;
    end
    if (nrst && phase_start && int'(select) != hang_sel) eng_cnt = done_lat;
  end

  // Output monitor: pops the scoreboard on every pulse.
  always @(negedge clk) begin
    if (nrst) begin
      if (!busy) prev_ps_cyc = -1;
      if (phase_start) begin
        ps_total++;
        if (exp_sel_q.size() == 0) check_val("unexpected_phase_start", 1, 0);
        else check_val("select", select, exp_sel_q.pop_front());
        if (prev_ps_cyc >= 0) check_val("ps_spacing", cyc - prev_ps_cyc, done_lat + 1);
        prev_ps_cyc = cyc;
        last_ps_cyc = cyc;
        $display("cycle %0d: phase_start select=%0d", cyc, select);
      end
      if (round_done) begin
        rd_total++;
        if (exp_cnt_q.size() == 0) check_val("unexpected_round_done", 1, 0);
        else check_val("round_count", round_count, exp_cnt_q.pop_front());
        $display("cycle %0d: round_done round_count=%0d", cyc, round_count);
      end
    end
  end

  task automatic start_round(input logic [7:0] m, input bit completes);
    @(negedge clk);
    start = 1'b1;
    phase_en = m;
    for (int i = 0; i < 8; i++) if (m[i]) exp_sel_q.push_back(i);
    if (completes) begin
      exp_count = (exp_count + 1) % CNT_MOD;
      exp_cnt_q.push_back(exp_count);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check_val("reached_idle", busy, 0);
    check_val("sel_queue_drained", exp_sel_q.size(), 0);
  endtask

  task automatic wait_phase(input int idx, input int budget);
    int n = 0;
    while (!(phase_start && int'(select) == idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("reached_phase", select, idx);
  endtask

  initial begin
    int ps0;
    int rd0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_select", select, 0);
    check_val("rst_phase_start", phase_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_round_done", round_done, 0);
    check_val("rst_timeout_err", timeout_err, 0);
    check_val("rst_err_phase", err_phase, 0);
    check_val("rst_round_count", round_count, 0);

    // Start held across reset release is accepted on the first edge.
    start = 1'b1;
    phase_en = 8'h01;
    exp_sel_q.push_back(0);
    exp_count = 1;
    exp_cnt_q.push_back(1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_val("first_start_launch", phase_start, 1);
    start = 1'b0;
    wait_idle(50);

    // All eight phases.
    ps0 = ps_total;
    start_round(8'hFF, 1);
    wait_idle(100);
    check_val("ff_phase_starts", ps_total - ps0, 8);
    check_val("ff_round_count", round_count, exp_count);

    // Sparse mask, plus a start while busy that must be ignored.
    start_round(8'hA4, 1);
    @(negedge clk);
    start = 1'b1;
    phase_en = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);

    // Empty mask: DONE directly, round_done two cycles after start.
    ps0 = ps_total;
    @(negedge clk);
    start = 1'b1;
    phase_en = 8'h00;
    exp_count = (exp_count + 1) % CNT_MOD;
    exp_cnt_q.push_back(exp_count);
    @(negedge clk);
    start = 1'b0;
    check_val("zero_mask_busy", busy, 1);
    check_val("zero_mask_no_rd_yet", round_done, 0);
    @(negedge clk);
    #1;
    check_val("zero_mask_round_done", round_done, 1);
    check_val("zero_mask_no_ps", ps_total - ps0, 0);

    // phase_done coincides with timer==limit: completion wins.
    timeout_limit = 16'd2;
    start_round(8'h81, 1);
    wait_idle(100);
    check_val("done_beats_timeout", timeout_err, 0);

    // Timeout on phase 3.
    timeout_limit = 16'd4;
    hang_sel = 3;
    start_round(8'h0A, 0);
    wait_idle(100);
    check_val("timeout_err", timeout_err, 1);
    check_val("err_phase", err_phase, 3);
    check_val("timeout_latency", cyc - last_ps_cyc, 6);
    check_val("timeout_round_count", round_count, exp_count);
    hang_sel = -1;
    timeout_limit = '0;
    start_round(8'h10, 1);
    check_val("timeout_err_cleared", timeout_err, 0);
    wait_idle(100);
    repeat (3) @(negedge clk);
    check_val("select_held_idle", select, 4);

    // Abort during WAIT of phase 5.
    hang_sel = 5;
    rd0 = rd_total;
    start_round(8'h3F, 0);
    wait_phase(5, 200);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_idle", busy, 0);
    check_val("abort_round_count", round_count, exp_count);
    repeat (4) @(negedge clk);
    check_val("abort_no_round_done", rd_total - rd0, 0);
    hang_sel = -1;

    // Asynchronous reset mid-round.
    start_round(8'hFF, 0);
    wait_phase(2, 200);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check_val("mid_rst_select", select, 0);
    check_val("mid_rst_phase_start", phase_start, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_round_done", round_done, 0);
    check_val("mid_rst_timeout_err", timeout_err, 0);
    check_val("mid_rst_err_phase", err_phase, 0);
    check_val("mid_rst_round_count", round_count, 0);
    exp_sel_q.delete();
    exp_cnt_q.delete();
    exp_count = 0;
    ps0 = ps_total;
    rd0 = rd_total;
    @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    check_val("post_rst_no_ps", ps_total - ps0, 0);
    check_val("post_rst_no_rd", rd_total - rd0, 0);

    // round_count wraps after 2^CNT_W - 1 rounds.
    for (int r = 0; r < CNT_MOD - 1; r++) begin
      start_round(8'h00, 1);
      wait_idle(20);
    end
    check_val("count_at_max", round_count, CNT_MOD - 1);
    start_round(8'h00, 1);
    wait_idle(20);
    check_val("count_wrapped", round_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
